// File: rtl/pe_output.sv
// Ejection port of the Cardinal ring router: one packet buffer per VC, cw/ccw
// round-robin per VC, delivery to the PE. Optional PE_OUT_CNT_EN adds pkt_count.
module pe_output #(
  parameter int DATA_WIDTH = 64
`ifdef PE_OUT_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  request_cw_even,
  input  logic                  request_cw_odd,
  input  logic                  request_ccw_even,
  input  logic                  request_ccw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_cw_even,
  input  logic [DATA_WIDTH-1:0] data_in_cw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_even,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_odd,
  output logic                  grant_cw_even,
  output logic                  grant_cw_odd,
  output logic                  grant_ccw_even,
  output logic                  grant_ccw_odd,
  input  logic                  pero,
  output logic                  peso,
  output logic [DATA_WIDTH-1:0] pedo
`ifdef PE_OUT_CNT_EN
  , output logic [CNT_WIDTH-1:0] pkt_count
`endif
);

  // VC index 0 is even, 1 is odd; polarity names the VC that accepts.
  logic [1:0]            w_req_cw;
  logic [1:0]            w_req_ccw;
  logic [1:0]            w_gnt_cw;
  logic [1:0]            w_gnt_ccw;
  logic [1:0]            w_open;
  logic [1:0]            w_send;
  logic                  w_snd_vc;
  logic [DATA_WIDTH-1:0] w_din_cw  [2];
  logic [DATA_WIDTH-1:0] w_din_ccw [2];

  logic                  r_full [2];
  logic                  r_rr   [2];
  logic [DATA_WIDTH-1:0] r_buf  [2];
  logic                  r_peso;
  logic [DATA_WIDTH-1:0] r_pedo;

  assign w_req_cw     = {request_cw_odd, request_cw_even};
  assign w_req_ccw    = {request_ccw_odd, request_ccw_even};
  assign w_din_cw[0]  = data_in_cw_even;
  assign w_din_cw[1]  = data_in_cw_odd;
  assign w_din_ccw[0] = data_in_ccw_even;
  assign w_din_ccw[1] = data_in_ccw_odd;
  assign w_snd_vc     = ~polarity;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      assign w_open[gi] = ~rst & ~r_full[gi] & (polarity == 1'(gi));
      assign w_send[gi] = r_full[gi] & pero & (polarity != 1'(gi));
      // rr=0 favours cw on a tie, rr=1 favours ccw.
      assign w_gnt_cw[gi]  = w_open[gi] & w_req_cw[gi]  & (~w_req_ccw[gi] | ~r_rr[gi]);
      assign w_gnt_ccw[gi] = w_open[gi] & w_req_ccw[gi] & (~w_req_cw[gi]  |  r_rr[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_full[gi] <= 1'b0;
          r_rr[gi]   <= 1'b0;
          r_buf[gi]  <= '0;
        end else if (w_gnt_cw[gi] || w_gnt_ccw[gi]) begin
          r_full[gi] <= 1'b1;
          r_rr[gi]   <= w_gnt_cw[gi];
          r_buf[gi]  <= w_gnt_cw[gi] ? w_din_cw[gi] : w_din_ccw[gi];
        end else if (w_send[gi]) begin
          r_full[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign grant_cw_even  = w_gnt_cw[0];
  assign grant_cw_odd   = w_gnt_cw[1];
  assign grant_ccw_even = w_gnt_ccw[0];
  assign grant_ccw_odd  = w_gnt_ccw[1];

  // Only the send VC can have w_send set, so r_buf[w_snd_vc] is the source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peso <= 1'b0;
      r_pedo <= '0;
    end else begin
      r_peso <= |w_send;
      if (|w_send) r_pedo <= r_buf[w_snd_vc];
    end
  end

  assign peso = r_peso;
  assign pedo = r_pedo;

`ifdef PE_OUT_CNT_EN
  logic [CNT_WIDTH-1:0] r_pkt_count;

  always_ff @(posedge clk) begin
    if (rst)          r_pkt_count <= '0;
    else if (|w_send) r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
  end

  assign pkt_count = r_pkt_count;
`endif

endmodule
